// File: rtl/text_pkg.sv
// Shared control codes, FSM state encodings and byte classification for the
// text-mode RAM writer.
package text_pkg;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_PUT   = 2'd1;
    localparam state_t S_CLEAR = 2'd2;

    // Codes that only move the cursor and keep the writer in IDLE.
    function automatic logic is_cursor_ctrl(input logic [7:0] code);
        return (code == CH_CR) || (code == CH_LF) || (code == CH_BS);
    endfunction

    function automatic logic is_printable(input logic [7:0] code);
        return !is_cursor_ctrl(code) && (code != CH_FF);
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Row/column cursor for the text writer: advance with wrap, home, carriage
// return, line feed and saturating backspace.
module text_cursor #(
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 5,
    parameter int ROWS     = 32,
    parameter int COLS     = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                inc,
    input  logic                home,
    input  logic                cr,
    input  logic                lf,
    input  logic                bs,
    output logic [ROW_BITS-1:0] row,
    output logic [COL_BITS-1:0] col
);

    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);

    logic [ROW_BITS-1:0] row_next_line;

    assign row_next_line = (row == ROW_LAST) ? '0 : row + ROW_BITS'(1);

    // Only one command is ever raised per cycle; the priority order is a tie-break.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row <= '0;
            col <= '0;
        end else if (home) begin
            row <= '0;
            col <= '0;
        end else if (lf) begin
            row <= row_next_line;
            col <= '0;
        end else if (cr) begin
            col <= '0;
        end else if (bs) begin
            if (col != '0) begin
                col <= col - COL_BITS'(1);
            end
        end else if (inc) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row_next_line;
            end else begin
                col <= col + COL_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/text_ram_writer.sv
// Byte-stream front end for the text display RAM: interprets control codes,
// and writes cells or clears the whole RAM only while the display is blanked.
module text_ram_writer
    import text_pkg::*;
#(
    parameter int         ROW_BITS   = 5,
    parameter int         COL_BITS   = 5,
    parameter int         ROWS       = 32,
    parameter int         COLS       = 32,
    parameter logic [7:0] BLANK_CHAR = 8'h0A
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         display_on,
    output logic [ROW_BITS+COL_BITS-1:0] ram_addr,
    output logic [7:0]                   ram_din,
    output logic                         ram_we,
    output logic                         busy,
    output logic [ROW_BITS-1:0]          cur_row,
    output logic [COL_BITS-1:0]          cur_col
);

    localparam int AW = ROW_BITS + COL_BITS;

    state_t          state;
    state_t          next_state;
    logic            armed;
    logic [AW-1:0]   sweep_addr;
    logic [AW-1:0]   put_addr;
    logic [7:0]      put_din;
    logic            accept;
    logic            sweep_last;
    logic            cur_inc;
    logic            cur_home;
    logic            cur_cr;
    logic            cur_lf;
    logic            cur_bs;

    assign accept     = in_valid && in_ready;
    assign sweep_last = &sweep_addr;

    assign cur_home = accept && (in_data == CH_FF);
    assign cur_cr   = accept && (in_data == CH_CR);
    assign cur_lf   = accept && (in_data == CH_LF);
    assign cur_bs   = accept && (in_data == CH_BS);
    assign cur_inc  = (state == S_PUT) && ram_we;

    text_cursor #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .ROWS     (ROWS),
        .COLS     (COLS)
    ) u_cursor (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (cur_inc),
        .home    (cur_home),
        .cr      (cur_cr),
        .lf      (cur_lf),
        .bs      (cur_bs),
        .row     (cur_row),
        .col     (cur_col)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_data == CH_FF) begin
                        next_state = S_CLEAR;
                    end else if (is_printable(in_data)) begin
                        next_state = S_PUT;
                    end
                end
            end
            S_PUT: begin
                if (ram_we) begin
                    next_state = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (ram_we && sweep_last) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_CLEAR;
        endcase
    end

    // The reset state is CLEAR, so writes are held off by 'armed' until the
    // first edge after release; asserting reset drops ram_we asynchronously.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = put_addr;
        ram_din  = put_din;
        if (state == S_CLEAR) begin
            ram_addr = sweep_addr;
            ram_din  = BLANK_CHAR;
        end
        if ((state == S_PUT) || (state == S_CLEAR)) begin
            ram_we = armed && !display_on;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed    <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
        end else begin
            armed    <= 1'b1;
            in_ready <= (next_state == S_IDLE);
            busy     <= (next_state == S_CLEAR);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sweep_addr <= '0;
        end else if (cur_home) begin
            sweep_addr <= '0;
        end else if ((state == S_CLEAR) && ram_we) begin
            sweep_addr <= sweep_addr + AW'(1);
        end
    end

    // Cell address and data are captured with the pre-advance cursor.
    always_ff @(posedge clk) begin
        if (accept && is_printable(in_data)) begin
            put_din  <= in_data;
            put_addr <= {cur_row, cur_col};
        end
    end

endmodule

// File: tb/tb_text_ram_writer.sv
// Scoreboard bench for text_ram_writer: a cursor model queues expected RAM
// writes, and a negedge monitor checks every ram_we pulse against the queue.
module tb_text_ram_writer;

    localparam int ROWS  = 32;
    localparam int COLS  = 32;
    localparam int NCELL = 1024;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       display_on;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_we;
    logic       busy;
    logic [4:0] cur_row;
    logic [4:0] cur_col;

    int compared   = 0;
    int mismatched = 0;
    int writes     = 0;
    int mode       = 2;   // 0: 160/800 low pattern, 1: high, 2: low, 3: random
    int pcnt       = 0;
    int m_row      = 0;
    int m_col      = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    text_ram_writer #(
        .ROW_BITS   (5),
        .COL_BITS   (5),
        .ROWS       (ROWS),
        .COLS       (COLS),
        .BLANK_CHAR (8'h0A)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .display_on (display_on),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .busy       (busy),
        .cur_row    (cur_row),
        .cur_col    (cur_col)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: bound expired", name);
    endtask

    initial begin
        display_on = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: begin
                    display_on = (pcnt >= 160);
                    pcnt = (pcnt + 1) % 800;
                end
                1: display_on = 1'b1;
                2: display_on = 1'b0;
                default: display_on = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every write must be expected, in order, and outside active video.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            writes++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: addr %0h din %0h", ram_addr, ram_din);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("write", 32'({display_on, ram_addr, ram_din}), 32'({1'b0, e}));
            end
        end
    end

    function automatic void push_clear();
        for (int i = 0; i < NCELL; i++) begin
            exp_q.push_back({10'(i), 8'h0A});
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        case (b)
            8'h0D: m_col = 0;
            8'h0A: begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end
            8'h08: if (m_col > 0) m_col--;
            8'h0C: begin
                m_row = 0;
                m_col = 0;
                push_clear();
            end
            default: begin
                exp_q.push_back({5'(m_row), 5'(m_col), b});
                m_col++;
                if (m_col == COLS) begin
                    m_col = 0;
                    m_row = (m_row + 1) % ROWS;
                end
            end
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            fail_now("send_ready");
            return;
        end
        in_data  = b;
        in_valid = 1'b1;
        model_byte(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for the sweep to end; flags any cycle with in_ready high meanwhile.
    task automatic wait_sweep(input string name);
        int t = 0;
        int ready_seen = 0;
        @(negedge clk);
        while (busy === 1'b1 && t < 20000) begin
            if (in_ready !== 1'b0) ready_seen++;
            @(negedge clk);
            t++;
        end
        if (busy !== 1'b0) fail_now(name);
        check({name, "_ready_low"}, 32'(ready_seen), 32'd0);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        @(negedge clk);
        while ((in_ready !== 1'b1 || exp_q.size() != 0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1 || exp_q.size() != 0) fail_now(name);
    endtask

    function automatic logic [7:0] rand_printable();
        return 8'($urandom_range(32'h20, 32'h7E));
    endfunction

    initial begin
        int w0;
        int we_in_reset;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset state, with the display blanked so a leaking write would show.
        repeat (3) @(negedge clk);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_cursor", 32'({cur_row, cur_col}), 32'd0);

        // Test 1: power-on clear under the 160/800 blanking pattern.
        push_clear();
        mode = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_sweep("t1_sweep");
        check("t1_writes", 32'(writes), 32'd1024);
        check("t1_queue", 32'(exp_q.size()), 32'd0);
        check("t1_ready", 32'(in_ready), 32'd1);

        // Test 2: a character held off by active video.
        mode = 1;
        repeat (2) @(negedge clk);
        w0 = writes;
        send_byte(8'h31);
        repeat (50) @(negedge clk);
        check("t2_no_write", 32'(writes), 32'(w0));
        check("t2_not_ready", 32'(in_ready), 32'd0);
        mode = 2;
        wait_drain("t2_drain");
        check("t2_one_write", 32'(writes), 32'(w0 + 1));
        check("t2_cursor", 32'({cur_row, cur_col}), 32'd1);

        // Test 3: one full row of characters.
        mode = 3;
        send_byte(8'h0D);
        for (int i = 0; i < 32; i++) send_byte(rand_printable());
        wait_drain("t3_drain");
        check("t3_cursor", 32'({cur_row, cur_col}), 32'({5'd1, 5'd0}));

        // Test 4: line feed on the last row wraps without writing.
        for (int i = 0; i < 30; i++) send_byte(8'h0A);
        for (int i = 0; i < 5; i++) send_byte(rand_printable());
        wait_drain("t4_drain");
        check("t4_at_31_5", 32'({cur_row, cur_col}), 32'({5'd31, 5'd5}));
        w0 = writes;
        send_byte(8'h0A);
        @(negedge clk);
        check("t4_ready_next", 32'(in_ready), 32'd1);
        check("t4_cursor", 32'({cur_row, cur_col}), 32'd0);
        check("t4_no_write", 32'(writes), 32'(w0));

        // Test 5: saturating backspace, random stream, then form feed.
        send_byte(8'h08);
        @(negedge clk);
        check("t5_bs_col0", 32'({cur_row, cur_col}), 32'd0);
        check("t5_bs_no_write", 32'(writes), 32'(w0));
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: send_byte(8'h0D);
                1: send_byte(8'h0A);
                2: send_byte(8'h08);
                default: send_byte(rand_printable());
            endcase
        end
        wait_drain("t5_stream");
        check("t5_stream_cursor", 32'({cur_row, cur_col}), 32'({5'(m_row), 5'(m_col)}));
        w0 = writes;
        send_byte(8'h0C);
        wait_sweep("t5_sweep");
        check("t5_ff_cursor", 32'({cur_row, cur_col}), 32'd0);
        check("t5_ff_writes", 32'(writes - w0), 32'd1024);
        for (int i = 0; i < 10; i++) send_byte(rand_printable());
        wait_drain("t5_after");
        check("t5_after_cursor", 32'({cur_row, cur_col}), 32'({5'(m_row), 5'(m_col)}));

        // Test 6: reset while a write waits in PUT.
        mode = 1;
        repeat (2) @(negedge clk);
        send_byte(8'h41);
        repeat (3) @(negedge clk);
        check("t6_in_put", 32'(in_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("t6_we_drop", 32'(ram_we), 32'd0);
        check("t6_rst_cursor", 32'({cur_row, cur_col}), 32'd0);
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        push_clear();
        mode = 2;
        we_in_reset = 0;
        repeat (4) begin
            @(negedge clk);
            if (ram_we !== 1'b0) we_in_reset++;
        end
        check("t6_we_held", 32'(we_in_reset), 32'd0);
        w0 = writes;
        mode = 3;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_sweep("t6_sweep");
        check("t6_writes", 32'(writes - w0), 32'd1024);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
